// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                        |
// | Brief    : Shared state encoding, divider math and legal parameter ranges  |
// |            for uart_rx_mb. Optional macro: UART_RX_MB_PARITY_EN            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int c_DATA_BITS_MIN  = 5;
  localparam int c_DATA_BITS_MAX  = 9;
  localparam int c_STOP_BITS_MIN  = 1;
  localparam int c_STOP_BITS_MAX  = 2;
  localparam int c_OVERSAMPLE_LO  = 8;
  localparam int c_OVERSAMPLE_HI  = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_MB_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5,
    S_DELIVER   = 3'd6
  } state_t;

  // Rounded clocks-per-oversample-tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    longint den;
    longint q;
    den = longint'(baud) * longint'(os);
    q   = (longint'(clk_hz) + den / 2) / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

endpackage
`default_nettype wire

// File: rtl/baudgen_os.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : baudgen_os                                                      |
// | Brief    : Oversample tick generator, one-cycle tick every DIV clocks,     |
// |            held cleared while ena is low.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module baudgen_os #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic ena,
  output logic tick
);

  localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (!ena || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = ena && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_mb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_mb                                                      |
// | Brief    : Oversampling UART receiver with majority vote, break handling,  |
// |            held output word and overrun pulse.                             |
// |            Optional macro: UART_RX_MB_PARITY_EN (adds parity bit check)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_rx_mb
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int               c_DIV       = calc_div(CLK_HZ, BAUDRATE, OVERSAMPLE);
  localparam int               c_OSW       = $clog2(OVERSAMPLE);
  localparam logic [c_OSW-1:0] c_SAMP0     = c_OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_OSW-1:0] c_SAMP1     = c_OSW'(OVERSAMPLE / 2);
  localparam logic [c_OSW-1:0] c_SAMP2     = c_OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [c_OSW-1:0] c_OS_LAST   = c_OSW'(OVERSAMPLE - 1);
  localparam logic [3:0]       c_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       c_STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if ((DATA_BITS < c_DATA_BITS_MIN) || (DATA_BITS > c_DATA_BITS_MAX) ||
        (STOP_BITS < c_STOP_BITS_MIN) || (STOP_BITS > c_STOP_BITS_MAX) ||
        ((OVERSAMPLE != c_OVERSAMPLE_LO) && (OVERSAMPLE != c_OVERSAMPLE_HI))) begin : g_bad_cfg
      $error("uart_rx_mb: illegal DATA_BITS, STOP_BITS or OVERSAMPLE");
    end
  endgenerate

  state_t               r_state;
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic                 r_rx_prev;
  logic [1:0]           r_warm;
  logic [c_OSW-1:0]     r_os_cnt;
  logic [3:0]           r_bit_cnt;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr;
  logic                 r_break;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr_o;
  logic                 r_overrun;
  logic                 w_tick;
  logic                 w_vote;
  logic                 w_vote_now;
  logic                 w_bit_end;
  logic                 w_start_edge;

  // r_warm keeps the post-reset settling of the synchroniser from looking like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_warm    <= 2'd0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  baudgen_os #(
    .DIV (c_DIV)
  ) u_baudgen (
    .clk  (clk),
    .rstn (rstn),
    .ena  (r_state != S_IDLE),
    .tick (w_tick)
  );

  assign w_start_edge = (r_warm == 2'd3) && r_rx_prev && !r_rx_sync;
  assign w_vote       = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_rx_sync) | (r_samp[0] & r_rx_sync);
  assign w_vote_now   = w_tick && (r_os_cnt == c_SAMP2);
  assign w_bit_end    = w_tick && (r_os_cnt == c_OS_LAST);

`ifdef UART_RX_MB_PARITY_EN
  logic r_perr;
  logic r_perr_o;
  assign parity_err = r_perr_o;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (PARITY_ODD != 0);
  assign parity_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= 4'd0;
      r_samp    <= 2'b11;
      r_shift   <= '0;
      r_ferr    <= 1'b0;
      r_break   <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_overrun <= 1'b0;
`ifdef UART_RX_MB_PARITY_EN
      r_perr    <= 1'b0;
      r_perr_o  <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && ready) r_valid <= 1'b0;
      if (w_tick) r_os_cnt <= (r_os_cnt == c_OS_LAST) ? '0 : r_os_cnt + 1'b1;
      if (w_tick && ((r_os_cnt == c_SAMP0) || (r_os_cnt == c_SAMP1)))
        r_samp <= {r_samp[0], r_rx_sync};

      case (r_state)
        S_IDLE: begin
          r_os_cnt  <= '0;
          r_bit_cnt <= 4'd0;
          r_ferr    <= 1'b0;
          r_break   <= 1'b0;
`ifdef UART_RX_MB_PARITY_EN
          r_perr    <= 1'b0;
`endif
          if (w_start_edge) r_state <= S_START;
        end

        S_START: begin
          if (w_vote_now && w_vote) r_state <= S_IDLE;
          else if (w_bit_end)       r_state <= S_DATA;
        end

        S_DATA: begin
          if (w_vote_now) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_bit_end) begin
            if (r_bit_cnt == c_DATA_LAST) begin
              r_bit_cnt <= 4'd0;
`ifdef UART_RX_MB_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end

`ifdef UART_RX_MB_PARITY_EN
        S_PARITY: begin
          if (w_vote_now) r_perr <= ((^r_shift) ^ w_vote) != (PARITY_ODD != 0);
          if (w_bit_end)  r_state <= S_STOP;
        end
`endif

        // The last stop bit ends at its vote so a following start edge is never missed.
        S_STOP: begin
          if (w_vote_now) begin
            if (!w_vote) r_ferr <= 1'b1;
            if (r_bit_cnt == 4'd0) r_break <= (r_shift == '0) && !w_vote;
            if (r_bit_cnt == c_STOP_LAST) r_state <= S_DELIVER;
          end
          if (w_bit_end) r_bit_cnt <= r_bit_cnt + 4'd1;
        end

        S_DELIVER: begin
          if (r_valid && !ready) begin
            r_overrun <= 1'b1;
          end else begin
            r_data   <= r_shift;
            r_ferr_o <= r_ferr;
            r_valid  <= 1'b1;
`ifdef UART_RX_MB_PARITY_EN
            r_perr_o <= r_perr;
`endif
          end
          r_state <= r_break ? S_WAIT_HIGH : S_IDLE;
        end

        S_WAIT_HIGH: begin
          if (r_rx_sync) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr_o;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_rx_mb                                                   |
// | Brief    : Scoreboard bench for uart_rx_mb; directed frames, glitch,       |
// |            overrun, framing error, break and mid-frame reset.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_rx_mb;

  // 12 MHz / (96000 * 16) = 7.8125 -> DIV 8, so one bit is 128 clocks.
  localparam int c_BIT = 16 * 8;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ovr_cnt  = 0;
  int   vcyc     = 0;
  logic unused_pflip;

  always #5 clk = ~clk;

  uart_rx_mb #(
    .CLK_HZ     (12000000),
    .BAUDRATE   (96000),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .OVERSAMPLE (16),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted word is matched against the oldest expectation.
  always @(negedge clk) begin
    if (valid) vcyc++;
    if (overrun) ovr_cnt++;
    if (rstn && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_data",   32'(data),       32'(e.d));
        check("word_ferr",   32'(frame_err),  32'(e.fe));
        check("word_perr",   32'(parity_err), 32'(e.pe));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clks(c_BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pflip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_MB_PARITY_EN
    drive_bit((^d) ^ pflip);
`else
    unused_pflip = pflip;
`endif
    drive_bit(stop_v);
  endtask

  task automatic expect_word(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    exp_q.push_back(e);
  endtask

  initial begin
    int ovr_base;
    rstn  = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    wait_clks(5);
    check("reset_valid",     32'(valid),      32'd0);
    check("reset_data",      32'(data),       32'd0);
    check("reset_frame_err", 32'(frame_err),  32'd0);
    check("reset_par_err",   32'(parity_err), 32'd0);
    check("reset_overrun",   32'(overrun),    32'd0);
    rstn = 1'b1;
    wait_clks(2 * c_BIT);

    // Plain 8N1 word, consumer always ready: valid lasts exactly one cycle.
    vcyc = 0;
    expect_word(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    wait_clks(2 * c_BIT);
    check("valid_cycles_55", 32'(vcyc), 32'd1);

    // Short low glitch is a false start.
    vcyc = 0;
    rx = 1'b0;
    wait_clks(50);
    rx = 1'b1;
    wait_clks(2 * c_BIT);
    check("glitch_valid_cycles", 32'(vcyc), 32'd0);
    expect_word(8'hA3, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    wait_clks(2 * c_BIT);

    // Back-to-back words with no consumer: second is dropped.
    ovr_base = ovr_cnt;
    ready = 1'b0;
    expect_word(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_clks(c_BIT);
    check("overrun_pulses", 32'(ovr_cnt - ovr_base), 32'd1);
    check("held_valid",     32'(valid),              32'd1);
    check("held_data",      32'(data),               32'h11);
    ready = 1'b1;
    wait_clks(4);
    check("valid_after_accept", 32'(valid), 32'd0);
    wait_clks(c_BIT);

    // Bad stop bit, then a long break, then a normal word.
    expect_word(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b1;
    wait_clks(2 * c_BIT);
    expect_word(8'h00, 1'b1, 1'b0);
    rx = 1'b0;
    wait_clks(20 * c_BIT);
    check("break_words_seen", 32'(exp_q.size()), 32'd0);
    rx = 1'b1;
    wait_clks(2 * c_BIT);
    expect_word(8'h7E, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_clks(2 * c_BIT);

`ifdef UART_RX_MB_PARITY_EN
    expect_word(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clks(c_BIT);
    expect_word(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(2 * c_BIT);
`endif

    // Hold a word, then reset in the middle of a frame's first data bit.
    ready = 1'b0;
    send_frame(8'h81, 1'b1, 1'b0);
    wait_clks(c_BIT);
    check("held_before_reset", 32'(valid), 32'd1);
    rx = 1'b0;
    wait_clks(c_BIT + c_BIT / 2);
    rstn = 1'b0;
    wait_clks(4);
    check("valid_in_reset", 32'(valid), 32'd0);
    check("data_in_reset",  32'(data),  32'd0);
    rstn  = 1'b1;
    ready = 1'b1;
    vcyc  = 0;
    wait_clks(2 * c_BIT);
    rx = 1'b1;
    wait_clks(10 * c_BIT);
    check("no_word_after_reset", 32'(vcyc), 32'd0);
    expect_word(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_clks(2 * c_BIT);

    check("pending_words", 32'(exp_q.size()), 32'd0);
    check("overrun_total", 32'(ovr_cnt),      32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
